// File: rtl/qlab5_pio_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : qlab5_pio_pkg
//  Description : Shared register addresses and edge-type encoding for the
//                qlab5 parallel I/O port family.
//  Revision    : 1.0 - initial release
// ============================================================================
package qlab5_pio_pkg;

    // Word addresses shared by every PIO variant on the qlab5 fabric
    localparam logic [2:0] PIO_ADDR_DATA    = 3'd0;
    localparam logic [2:0] PIO_ADDR_DIR     = 3'd1;
    localparam logic [2:0] PIO_ADDR_IRQMASK = 3'd2;
    localparam logic [2:0] PIO_ADDR_EDGECAP = 3'd3;

    // Which input transition sets an edge-capture bit
    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_ANY  = 2'd2
    } pio_edge_e;

endpackage
`default_nettype wire

// File: rtl/qlab5_pio_sync.sv
`default_nettype none
// ============================================================================
//  Module      : qlab5_pio_sync
//  Description : Per-bit multi-flop synchronizer for asynchronous inputs.
//                Every bit of d passes through STAGES flops; q is the last.
//  Revision    : 1.0 - initial release
// ============================================================================
module qlab5_pio_sync #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_stage [STAGES];

    // Shift the raw inputs down the synchronizer chain
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < STAGES; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign q = r_stage[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/qlab5_pio_in.sv
`default_nettype none
// ============================================================================
//  Module      : qlab5_pio_in
//  Description : Avalon-MM parallel input port. Synchronizes in_port, exposes
//                its level, a per-bit edge-capture register (write-1-to-clear)
//                and an interrupt mask, and drives a level interrupt.
//  Revision    : 1.0 - initial release
// ============================================================================
module qlab5_pio_in
    import qlab5_pio_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter int               EDGE_TYPE   = 0,
    parameter int               SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] RESET_MASK  = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    // Warm-up counter runs from 0 up to SYNC_STAGES, then arms on the next edge
    localparam int                 c_CNT_W    = $clog2(SYNC_STAGES + 2);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(SYNC_STAGES);

    logic [WIDTH-1:0]   w_sync;
    logic [WIDTH-1:0]   r_prev;
    logic [WIDTH-1:0]   w_edge;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_armed;
    logic [WIDTH-1:0]   r_edgecap;
    logic [WIDTH-1:0]   r_irqmask;
    logic               w_wr;
    logic [WIDTH-1:0]   w_clr;
    logic [31:0]        w_rd;

    qlab5_pio_sync #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (in_port),
        .q       (w_sync)
    );

    // Delay the synchronized level one cycle for edge comparison
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev <= '0;
        end else begin
            r_prev <= w_sync;
        end
    end

    // Select the transition that counts as an edge
    if (EDGE_TYPE == int'(EDGE_FALL)) begin : g_edge_fall
        assign w_edge = ~w_sync & r_prev;
    end else if (EDGE_TYPE == int'(EDGE_ANY)) begin : g_edge_any
        assign w_edge = w_sync ^ r_prev;
    end else begin : g_edge_rise
        assign w_edge = w_sync & ~r_prev;
    end

    // Hold off capture until the synchronizer has flushed its reset contents,
    // so levels already present at reset release are not seen as edges
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt   <= '0;
            r_armed <= 1'b0;
        end else if (!r_armed) begin
            if (r_cnt == c_CNT_LAST) begin
                r_armed <= 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign w_wr  = chipselect & ~write_n;
    assign w_clr = (w_wr && (address == PIO_ADDR_EDGECAP)) ? writedata[WIDTH-1:0] : '0;

    // Edge capture: clear by write-1, with a new edge taking priority
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_edgecap <= '0;
        end else begin
            r_edgecap <= (r_edgecap & ~w_clr) | (w_edge & {WIDTH{r_armed}});
        end
    end

    // Interrupt mask register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irqmask <= RESET_MASK;
        end else if (w_wr && (address == PIO_ADDR_IRQMASK)) begin
            r_irqmask <= writedata[WIDTH-1:0];
        end
    end

    // Read mux, zero-extended; reserved addresses read as zero
    always_comb begin
        w_rd = '0;
        case (address)
            PIO_ADDR_DATA:    w_rd[WIDTH-1:0] = w_sync;
            PIO_ADDR_IRQMASK: w_rd[WIDTH-1:0] = r_irqmask;
            PIO_ADDR_EDGECAP: w_rd[WIDTH-1:0] = r_edgecap;
            default:          w_rd            = '0;
        endcase
    end

    // Read data is registered every cycle regardless of chipselect
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= w_rd;
        end
    end

    assign irq = |(r_edgecap & r_irqmask);

    // Upper write-data bits have no destination when the port is narrow
    if (WIDTH < 32) begin : g_wd_upper
        logic w_unused_wd;
        assign w_unused_wd = |writedata[31:WIDTH];
    end

endmodule
`default_nettype wire

// File: tb/tb_qlab5_pio_in.sv
`default_nettype none
// ============================================================================
//  Module      : tb_qlab5_pio_in
//  Description : Self-checking bench for qlab5_pio_in. Two instances (rising
//                and any-edge capture) share one bus and input stimulus and
//                are compared against a history-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_qlab5_pio_in;

    localparam int W = 8;
    localparam int S = 2;
    localparam int HMAX = 8191;

    logic        clk        = 1'b0;
    logic        reset_n    = 1'b0;
    logic [2:0]  address    = 3'd0;
    logic        chipselect = 1'b0;
    logic        write_n    = 1'b1;
    logic [31:0] writedata  = 32'h0;
    logic [7:0]  in_port    = 8'h00;
    logic [31:0] rd_r, rd_a;
    logic        irq_r, irq_a;

    qlab5_pio_in #(.WIDTH(W), .EDGE_TYPE(0), .SYNC_STAGES(S), .RESET_MASK(8'h00)) dut_r (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_r),
        .in_port(in_port), .irq(irq_r)
    );

    qlab5_pio_in #(.WIDTH(W), .EDGE_TYPE(2), .SYNC_STAGES(S), .RESET_MASK(8'h00)) dut_a (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_a),
        .in_port(in_port), .irq(irq_a)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: hist[j] is in_port as sampled at the j-th edge after
    // reset release; the synchronized level lags that history by S-1 edges.
    logic [7:0]  hist [0:HMAX];
    int          k;
    logic [7:0]  m_ec_r, m_ec_a, m_mask;
    logic [31:0] m_rd_r, m_rd_a;

    function automatic logic [7:0] h(int j);
        if (j >= 1 && j <= HMAX) return hist[j];
        return 8'h00;
    endfunction

    task automatic model_reset();
        k      = 0;
        m_ec_r = 8'h00;
        m_ec_a = 8'h00;
        m_mask = 8'h00;
        m_rd_r = 32'h0;
        m_rd_a = 32'h0;
    endtask

    task automatic tick();
        logic [7:0] s, p, cap_r, cap_a, clr;
        logic       armed, wr;
        @(posedge clk);
        if (!reset_n) begin
            model_reset();
        end else begin
            s     = h(k - S + 1);
            p     = h(k - S);
            armed = (k >= S + 1);
            cap_r = armed ? (s & ~p) : 8'h00;
            cap_a = armed ? (s ^ p)  : 8'h00;
            case (address)
                3'd0:    begin m_rd_r = {24'h0, s};      m_rd_a = {24'h0, s};      end
                3'd2:    begin m_rd_r = {24'h0, m_mask}; m_rd_a = {24'h0, m_mask}; end
                3'd3:    begin m_rd_r = {24'h0, m_ec_r}; m_rd_a = {24'h0, m_ec_a}; end
                default: begin m_rd_r = 32'h0;           m_rd_a = 32'h0;           end
            endcase
            wr     = chipselect && !write_n;
            clr    = (wr && address == 3'd3) ? writedata[7:0] : 8'h00;
            m_ec_r = (m_ec_r & ~clr) | cap_r;
            m_ec_a = (m_ec_a & ~clr) | cap_a;
            if (wr && address == 3'd2) m_mask = writedata[7:0];
            k = k + 1;
            if (k <= HMAX) hist[k] = in_port;
        end
        #1;
    endtask

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_model(string tag);
        check({tag, "_rd_r"},  rd_r, m_rd_r);
        check({tag, "_rd_a"},  rd_a, m_rd_a);
        check({tag, "_irq_r"}, 32'(irq_r), 32'(|(m_ec_r & m_mask)));
        check({tag, "_irq_a"}, 32'(irq_a), 32'(|(m_ec_a & m_mask)));
    endtask

    task automatic tickc(string tag);
        tick();
        chk_model(tag);
    endtask

    task automatic wr(logic [2:0] a, logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b0;
        writedata  = d;
        tickc("wr");
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(logic [2:0] a);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        tickc("rd");
        chipselect = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        // Reset state with inputs already high through release
        in_port = 8'hFF;
        reset_n = 1'b0;
        repeat (3) tick();
        check("rst_rd_r",  rd_r, 32'h0);
        check("rst_rd_a",  rd_a, 32'h0);
        check("rst_irq_r", 32'(irq_r), 32'h0);
        check("rst_irq_a", 32'(irq_a), 32'h0);
        reset_n = 1'b1;
        address = 3'd3;
        repeat (10) tickc("warm");
        check("warm_ec_r", rd_r, 32'h0);
        check("warm_ec_a", rd_a, 32'h0);
        check("warm_irq",  32'(irq_r), 32'h0);
        rd(3'd0);
        check("warm_data", rd_r, 32'hFF);

        // Rising edge on bit 0 with mask 01, irq S cycles after sampling
        wr(3'd2, 32'h01);
        in_port = 8'h00;
        repeat (4) tickc("fall");
        wr(3'd3, 32'hFF);
        address = 3'd3;
        in_port = 8'h01;
        tickc("b0_n");
        check("b0_irq_n",  32'(irq_r), 32'h0);
        tickc("b0_n1");
        check("b0_irq_n1", 32'(irq_r), 32'h0);
        tickc("b0_n2");
        check("b0_irq_n2", 32'(irq_r), 32'h1);
        tickc("b0_rd");
        check("b0_ec", rd_r, 32'h01);
        wr(3'd3, 32'h01);
        check("b0_clr_irq", 32'(irq_r), 32'h0);

        // Masked-off capture on bit 3, then enabling the mask raises irq
        wr(3'd2, 32'h00);
        in_port = 8'h09;
        repeat (3) tickc("b3");
        rd(3'd3);
        check("b3_ec",  rd_r, 32'h08);
        check("b3_irq", 32'(irq_r), 32'h0);
        wr(3'd2, 32'h08);
        check("b3_mask_irq", 32'(irq_r), 32'h1);

        // Capture and clear landing on the same edge: set wins
        wr(3'd3, 32'hFF);
        in_port = 8'h0D;
        tickc("sw_n");
        tickc("sw_n1");
        wr(3'd3, 32'h04);
        rd(3'd3);
        check("setwins", rd_r & 32'h4, 32'h4);

        // Any-edge: rise and later fall on bit 5 give two captures
        wr(3'd3, 32'hFF);
        wr(3'd2, 32'h20);
        in_port = 8'h2D;
        repeat (3) tickc("b5r");
        rd(3'd3);
        check("b5_rise_a",   rd_a, 32'h20);
        check("b5_irq_a",    32'(irq_a), 32'h1);
        rd(3'd3);
        check("b5_noclr_rd", rd_a, 32'h20);
        wr(3'd3, 32'h20);
        in_port = 8'h0D;
        repeat (3) tickc("b5f");
        rd(3'd3);
        check("b5_fall_a", rd_a, 32'h20);
        check("b5_fall_r", rd_r, 32'h00);

        // Randomized bus traffic and input activity against the model
        repeat (300) begin
            if ($urandom_range(0, 2) != 0) in_port = 8'($urandom);
            address    = 3'($urandom_range(0, 7));
            chipselect = 1'($urandom_range(0, 1));
            write_n    = ($urandom_range(0, 3) != 0);
            writedata  = $urandom;
            tickc("rand");
        end
        chipselect = 1'b0;
        write_n    = 1'b1;

        // Load all capture bits, then sweep the map with a reset mid-sweep
        wr(3'd2, 32'hFF);
        in_port = 8'h00;
        repeat (4) tickc("pre");
        wr(3'd3, 32'hFF);
        in_port = 8'hFF;
        repeat (3) tickc("pre2");
        check("pre_irq", 32'(irq_r), 32'h1);
        for (int a = 0; a < 8; a++) begin
            rd(3'(a));
            if (a == 1 || a >= 4) check("sweep_rsvd", rd_r, 32'h0);
            if (a == 3) begin
                #2;
                reset_n = 1'b0;
                model_reset();
                #1;
                check("mid_rst_rd_r", rd_r, 32'h0);
                check("mid_rst_rd_a", rd_a, 32'h0);
                check("mid_rst_irq_r", 32'(irq_r), 32'h0);
                check("mid_rst_irq_a", 32'(irq_a), 32'h0);
            end
        end

        // Warm-up repeats after the second release
        reset_n = 1'b1;
        address = 3'd3;
        repeat (10) tickc("warm2");
        check("warm2_ec", rd_a, 32'h0);
        rd(3'd0);
        check("warm2_data", rd_r, 32'hFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
